// File: rtl/spike_raster_decoder_if.sv
// Bus bundle for the spike raster decoder: inbound spike-time stream,
// outbound raster steps and the error pulses.
// The slave modport is the decoder's view; master is the driving side.
interface spike_raster_decoder_if #(
  parameter int N  = 32,
  parameter int T  = 1,
  parameter int TA = 1,
  parameter int TS = 33,
  parameter int NN = 1,
  parameter int SW = 6
);
  logic [8*NN-1:0] s_tdata;
  logic            s_tvalid;
  logic            s_tready;
  logic            s_tlast;
  logic [N-1:0]    m_spikes;
  logic [SW-1:0]   m_step;
  logic [TA-1:0]   m_block;
  logic            m_valid;
  logic            m_ready;
  logic            m_last;
  logic            m_frame_last;
  logic            err_len;
  logic            err_range;

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_ready,
    output s_tready, m_spikes, m_step, m_block, m_valid, m_last,
           m_frame_last, err_len, err_range
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_ready,
    input  s_tready, m_spikes, m_step, m_block, m_valid, m_last,
           m_frame_last, err_len, err_range
  );
endinterface

// File: rtl/spike_raster_decoder.sv
// Spike raster decoder: buffers one block of N spike times from an
// AXI4-Stream, then replays TS time steps of N-bit spike vectors.
// Single buffer, so loading and playback alternate strictly.
module spike_raster_decoder #(
  parameter int N  = 32,
  parameter int T  = 1,
  parameter int TA = 1,
  parameter int TS = 33,
  parameter int NN = 1,
  parameter int SW = 6
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  spike_raster_decoder_if.slave  bus
);
  localparam int DW = 8 * NN;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  // Time value meaning "did not fire"; anything above it is out of range.
  localparam logic [DW-1:0] NO_SPIKE   = DW'(TS);
  localparam logic [BW-1:0] BEAT_LAST  = BW'(N - 1);
  localparam logic [SW-1:0] STEP_LAST  = SW'(TS - 1);
  localparam logic [TA-1:0] BLOCK_LAST = TA'(T - 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_PLAY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [DW-1:0]   time_q  [N];
  logic [DW-1:0]   time_nx [N];
  logic            tready_q, tready_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    spikes_q, spikes_d;
  logic [SW-1:0]   step_q, step_d;
  logic [TA-1:0]   block_q, block_d;
  logic            last_q, last_d;
  logic            flast_q, flast_d;
  logic            err_len_q, err_len_d;
  logic            err_range_q, err_range_d;

  logic accept_s;
  logic block_end_s;
  logic m_hs_s;
  logic play_done_s;

  // tready is only ever high in LOAD, so an accepted beat implies LOAD.
  assign accept_s    = bus.s_tvalid && tready_q;
  assign block_end_s = accept_s && (bus.s_tlast || (beat_q == BEAT_LAST));
  assign m_hs_s      = valid_q && bus.m_ready;
  assign play_done_s = m_hs_s && (step_q == STEP_LAST);

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: LOAD until block end, PLAY until the last step handshakes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_LOAD: begin
        if (block_end_s) state_d = ST_PLAY;
        else             state_d = ST_LOAD;
      end
      ST_PLAY: begin
        if (play_done_s) state_d = ST_LOAD;
        else             state_d = ST_PLAY;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Effective buffer contents after this cycle's write, including the
  // no-spike fill behind an early tlast, so step 0 can be computed at once.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (accept_s && (BW'(i) == beat_q)) begin
        time_nx[i] = bus.s_tdata;
      end else if (block_end_s && (BW'(i) > beat_q)) begin
        time_nx[i] = NO_SPIKE;
      end else begin
        time_nx[i] = time_q[i];
      end
    end
  end

  // Output / datapath next values for each state.
  always_comb begin
    beat_d      = beat_q;
    step_d      = step_q;
    block_d     = block_q;
    valid_d     = valid_q;
    tready_d    = (state_d == ST_LOAD);
    err_len_d   = accept_s && (bus.s_tlast != (beat_q == BEAT_LAST));
    err_range_d = accept_s && (bus.s_tdata > NO_SPIKE);
    case (state_q)
      ST_LOAD: begin
        if (block_end_s) begin
          beat_d  = '0;
          valid_d = 1'b1;
          step_d  = '0;
        end else if (accept_s) begin
          beat_d  = beat_q + BW'(1);
          valid_d = 1'b0;
        end else begin
          beat_d  = beat_q;
          valid_d = 1'b0;
        end
      end
      ST_PLAY: begin
        beat_d = '0;
        if (play_done_s) begin
          valid_d = 1'b0;
          step_d  = '0;
          block_d = (block_q == BLOCK_LAST) ? '0 : block_q + TA'(1);
        end else if (m_hs_s) begin
          valid_d = 1'b1;
          step_d  = step_q + SW'(1);
        end else begin
          valid_d = valid_q;
          step_d  = step_q;
        end
      end
      default: begin
        beat_d  = '0;
        valid_d = 1'b0;
        step_d  = '0;
      end
    endcase
    last_d   = valid_d && (step_d == STEP_LAST);
    flast_d  = last_d && (block_d == BLOCK_LAST);
    spikes_d = '0;
    for (int i = 0; i < N; i++) begin
      spikes_d[i] = valid_d && (time_nx[i] == DW'(step_d));
    end
  end

  // Control and output registers; everything returns to idle on reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_q      <= '0;
      tready_q    <= 1'b0;
      valid_q     <= 1'b0;
      spikes_q    <= '0;
      step_q      <= '0;
      block_q     <= '0;
      last_q      <= 1'b0;
      flast_q     <= 1'b0;
      err_len_q   <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      beat_q      <= beat_d;
      tready_q    <= tready_d;
      valid_q     <= valid_d;
      spikes_q    <= spikes_d;
      step_q      <= step_d;
      block_q     <= block_d;
      last_q      <= last_d;
      flast_q     <= flast_d;
      err_len_q   <= err_len_d;
      err_range_q <= err_range_d;
    end
  end

  // Spike-time buffer; contents are meaningless until a block is loaded.
  always_ff @(posedge aclk) begin
    for (int i = 0; i < N; i++) begin
      time_q[i] <= time_nx[i];
    end
  end

  assign bus.s_tready     = tready_q;
  assign bus.m_valid      = valid_q;
  assign bus.m_spikes     = spikes_q;
  assign bus.m_step       = step_q;
  assign bus.m_block      = block_q;
  assign bus.m_last       = last_q;
  assign bus.m_frame_last = flast_q;
  assign bus.err_len      = err_len_q;
  assign bus.err_range    = err_range_q;
endmodule
